// File: rtl/instr_fetch.sv
// Instruction fetch: issues imem word reads, captures data 1 cycle later and queues it in a 2-entry buffer for decode.
// First out_valid 2 edges after reset/redirect; issue stalls when buffer+inflight would exceed 2 (out_ready low).
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_1000,
  parameter logic [19:0] IMEM_REGION = 20'h00001,
  parameter int          ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [31:0]           imem_data_in,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic                  out_fault
);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_pc_d [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];
  logic        ent_fault_q [2];
  logic        ent_fault_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic       pop;
  logic       push;
  logic       can_issue;
  logic       illegal;
  logic [2:0] occupancy;

  assign imem_address = req_pc_q[ADDR_WIDTH+1:2];
  assign out_valid    = (count_q != 2'd0);
  assign out_pc       = out_valid ? ent_pc_q[rd_ptr_q]    : 32'h0;
  assign out_instr    = out_valid ? ent_instr_q[rd_ptr_q] : 32'h0;
  assign out_fault    = out_valid ? ent_fault_q[rd_ptr_q] : 1'b0;

  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !redirect_valid;
  assign illegal   = (req_pc_q[31:12] != IMEM_REGION) || (req_pc_q[1:0] != 2'b00);
  // Slots already promised (buffered + inflight) must leave room once this cycle's pop retires.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign can_issue = (state_q == S_RUN) && !redirect_valid &&
                     (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    inflight_d   = inflight_q;
    resp_pc_d    = resp_pc_q;
    resp_fault_d = resp_fault_q;
    ent_pc_d     = ent_pc_q;
    ent_instr_d  = ent_instr_q;
    ent_fault_d  = ent_fault_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (redirect_valid) begin
      state_d    = S_RUN;
      req_pc_d   = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        ent_pc_d[wr_ptr_q]    = resp_pc_q;
        ent_instr_d[wr_ptr_q] = resp_fault_q ? 32'h0 : imem_data_in;
        ent_fault_d[wr_ptr_q] = resp_fault_q;
        wr_ptr_d              = ~wr_ptr_q;
        inflight_d            = 1'b0;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (can_issue) begin
        inflight_d   = 1'b1;
        resp_pc_d    = req_pc_q;
        resp_fault_d = illegal;
        if (illegal) begin
          state_d = S_HALT;
        end else begin
          req_pc_d = req_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      req_pc_q     <= RESET_PC;
      inflight_q   <= 1'b0;
      resp_pc_q    <= 32'h0;
      resp_fault_q <= 1'b0;
      ent_pc_q     <= '{default: '0};
      ent_instr_q  <= '{default: '0};
      ent_fault_q  <= '{default: '0};
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      resp_pc_q    <= resp_pc_d;
      resp_fault_q <= resp_fault_d;
      ent_pc_q     <= ent_pc_d;
      ent_instr_q  <= ent_instr_d;
      ent_fault_q  <= ent_fault_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC    = 32'h0000_1000;
  localparam logic [19:0] IMEM_REGION = 20'h00001;
  localparam int          ADDR_WIDTH  = 10;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_data_in;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [31:0]           out_pc;
  logic                  out_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .IMEM_REGION(IMEM_REGION),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_address  (imem_address),
    .imem_data_in  (imem_data_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_fault     (out_fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word[i] = 0x1000_0000 + i
  always @(posedge clk) imem_data_in <= 32'h1000_0000 + {22'd0, imem_address};

  // Expected fetch result for a PC, straight from the legality rule and memory contents
  function automatic exp_t model(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.fault = (pc[31:12] != IMEM_REGION) || (pc[1:0] != 2'b00);
    e.instr = e.fault ? 32'h0 : (32'h1000_0000 + {22'd0, pc[11:2]});
    return e;
  endfunction

  // A fetch stream runs sequentially from its start PC up to and including the first faulting PC
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    exp_t e;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 1100; i++) begin
      e = model(pc);
      exp_q.push_back(e);
      if (e.fault) break;
      pc = pc + 32'd4;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    load_stream(pc);
    #1;
    redirect_valid = 1'b0;
  endtask

  // Monitor: every handshake must match the head of the expected stream
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_checks++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got pc=%h fault=%b, expected no output", out_pc, out_fault);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr, out_fault} !== {e.pc, e.instr, e.fault}) begin
          n_fail++;
          $display("FAIL out_entry: got pc=%h instr=%h fault=%b, expected pc=%h instr=%h fault=%b",
                   out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
        end
      end
    end
  end

  initial begin
    logic [31:0] rp;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [31:0] held_pc;
    logic [31:0] rpc;
    int pops_before;
    rp             = RESET_PC;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_fault", {31'd0, out_fault}, 32'd0);
    check("rst_imem_addr", {22'd0, imem_address}, {22'd0, rp[11:2]});
    tick();
    tick();
    load_stream(RESET_PC);
    rst_n = 1'b1;

    // First output after the 2nd edge following release
    tick();
    check("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge2_pc", out_pc, RESET_PC);

    for (int i = 0; i < 20; i++) begin
      tick();
      check("throughput_valid", {31'd0, out_valid}, 32'd1);
    end

    // Stall: buffer saturates, address and head freeze
    out_ready = 1'b0;
    tick();
    tick();
    held_addr = imem_address;
    held_pc   = out_pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", {22'd0, imem_address}, {22'd0, held_addr});
      check("stall_head_pc", out_pc, held_pc);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Redirect while the buffer is full
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    do_redirect(32'h0000_1100);
    check("redir_flush_e0", {31'd0, out_valid}, 32'd0);
    tick();
    check("redir_flush_e1", {31'd0, out_valid}, 32'd0);
    tick();
    check("redir_first_valid", {31'd0, out_valid}, 32'd1);
    check("redir_first_pc", out_pc, 32'h0000_1100);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Run off the end of the region into a fault, then stay quiet
    do_redirect(32'h0000_1F00);
    for (int i = 0; i < 80; i++) tick();
    check("region_end_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_quiet", {31'd0, out_valid}, 32'd0);
    end
    do_redirect(32'h0000_1000);
    for (int i = 0; i < 6; i++) tick();
    check("resume_valid", {31'd0, out_valid}, 32'd1);

    // Misaligned redirect: one fault entry only
    do_redirect(32'h0000_1002);
    for (int i = 0; i < 8; i++) tick();
    check("misaligned_drained", exp_q.size(), 32'd0);
    check("misaligned_quiet", {31'd0, out_valid}, 32'd0);

    // Redirect coinciding with a pop
    do_redirect(32'h0000_1000);
    for (int i = 0; i < 5; i++) tick();
    check("pop_at_redirect_valid", {31'd0, out_valid}, 32'd1);
    do_redirect(32'h0000_1800);
    for (int i = 0; i < 6; i++) tick();

    // Randomised backpressure and redirects
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0) begin
        case ($urandom_range(7))
          0:       rpc = $urandom();
          1:       rpc = 32'h0000_1000 | ($urandom() & 32'hFFF);
          default: rpc = 32'h0000_1000 | ($urandom() & 32'hFFC);
        endcase
        do_redirect(rpc);
      end else begin
        tick();
      end
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    do_redirect(32'h0000_1000);
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_pc", out_pc, 32'd0);
    tick();
    tick();
    load_stream(RESET_PC);
    rst_n = 1'b1;
    pops_before = n_pops;
    for (int i = 0; i < 10; i++) tick();
    check("restart_progress", {31'd0, (n_pops - pops_before) >= 8}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
